// File: rtl/mem_lsu_serial.sv
// ---------------------------------------------------------------------------
// mem_lsu_serial
//
// MEM-stage load/store unit that serialises byte/half/word/double accesses
// into MEM_W-wide beats on a shared, arbitrated memory port. Each beat is
// held on the port until the arbiter grants it. Load results are sign- or
// zero-extended. The pipeline is stalled until the access completes.
// Non-memory instructions pass straight through to WB with zero latency.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   op_valid_i          MEM stage holds a load/store this cycle
//   op_we_i             1 = store, 0 = load
//   op_size_i           00 byte, 01 half, 10 word, 11 double (word if XLEN=32)
//   op_unsigned_i       loads: 1 = zero-extend, 0 = sign-extend
//   addr_i              effective byte address (any alignment)
//   data_i              store data, or ALU result for pass-through
//   wd_i, wreg_i        destination register index / write enable
//   mem_gnt_i           arbiter grant for the beat currently on the port
//   mem_rdata_i         read data, valid one cycle after a granted read beat
//   mem_req_o .. mem_wdata_o   registered beat request, address, write flag,
//                              byte enables (lane 0 = mem_addr_o), write data
//   stall_o             freeze IF/ID/EX/MEM pipeline registers
//   wd_o, wreg_o, data_o       result towards WB
// ---------------------------------------------------------------------------
module mem_lsu_serial #(
    parameter int XLEN   = 32,
    parameter int MEM_W  = 8,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid_i,
    input  logic                 op_we_i,
    input  logic [1:0]           op_size_i,
    input  logic                 op_unsigned_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [XLEN-1:0]      data_i,
    input  logic [REG_AW-1:0]    wd_i,
    input  logic                 wreg_i,
    input  logic                 mem_gnt_i,
    input  logic [MEM_W-1:0]     mem_rdata_i,
    output logic                 mem_req_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_we_o,
    output logic [MEM_W/8-1:0]   mem_be_o,
    output logic [MEM_W-1:0]     mem_wdata_o,
    output logic                 stall_o,
    output logic [REG_AW-1:0]    wd_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      data_o
);

    localparam int L  = MEM_W / 8;          // byte lanes per beat
    localparam int NB = XLEN / 8;           // bytes per register
    localparam int BW = $clog2(NB) + 1;     // beat index / beat count width

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // A "double" on a 32-bit core is treated as a word.
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        if (XLEN == 32 && sz == 2'd3) return 2'd2;
        return sz;
    endfunction

    function automatic logic [BW-1:0] num_beats(input logic [1:0] sz);
        int b;
        b = 1 << sz;
        return BW'((b + L - 1) / L);
    endfunction

    // Low min(L, B - k*L) lanes enabled.
    function automatic logic [L-1:0] beat_be(input logic [1:0] sz, input logic [BW-1:0] k);
        int rem;
        logic [L-1:0] be;
        rem = (1 << sz) - int'(k) * L;
        be  = '0;
        for (int j = 0; j < L; j++) be[j] = (j < rem);
        return be;
    endfunction

    function automatic logic [MEM_W-1:0] beat_wdata(input logic [XLEN-1:0] d, input logic [BW-1:0] k);
        return MEM_W'(d >> (8 * L * int'(k)));
    endfunction

    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a, input logic [BW-1:0] k);
        return a + ADDR_W'(int'(k) * L);
    endfunction

    // Extend the low 8<<sz bits of the read buffer to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] b, input logic [1:0] sz,
                                               input logic uns);
        int nbits;
        logic fill;
        logic [XLEN-1:0] r;
        nbits = 8 << sz;
        fill  = uns ? 1'b0 : b[nbits-1];
        for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? b[i] : fill;
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [REG_AW-1:0]  wd_q, wd_d;
    logic               wreg_q, wreg_d;
    logic               req_q, req_d;
    logic               pwe_q, pwe_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [L-1:0]       pbe_q, pbe_d;
    logic [MEM_W-1:0]   pwdata_q, pwdata_d;
    logic [XLEN-1:0]    rbuf_q, rbuf_d;
    // A granted read beat whose data arrives on mem_rdata_i this cycle.
    logic               pend_q, pend_d;
    logic [BW-1:0]      pend_beat_q, pend_beat_d;
    logic [L-1:0]       pend_be_q, pend_be_d;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        req_d       = req_q;
        pwe_d       = pwe_q;
        paddr_d     = paddr_q;
        pbe_d       = pbe_q;
        pwdata_d    = pwdata_q;
        rbuf_d      = rbuf_q;
        pend_d      = 1'b0;
        pend_beat_d = pend_beat_q;
        pend_be_d   = pend_be_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid_i) begin
                    state_d  = S_ACCESS;
                    we_d     = op_we_i;
                    size_d   = eff_size(op_size_i);
                    uns_d    = op_unsigned_i;
                    addr_d   = addr_i;
                    data_d   = data_i;
                    wd_d     = wd_i;
                    wreg_d   = wreg_i;
                    beat_d   = '0;
                    req_d    = 1'b1;
                    pwe_d    = op_we_i;
                    paddr_d  = addr_i;
                    pbe_d    = beat_be(eff_size(op_size_i), '0);
                    pwdata_d = beat_wdata(data_i, '0);
                end
            end
            S_ACCESS: begin
                if (mem_gnt_i) begin
                    if (!we_q) begin
                        pend_d      = 1'b1;
                        pend_beat_d = beat_q;
                        pend_be_d   = pbe_q;
                    end
                    if ((beat_q + BW'(1)) == num_beats(size_q)) begin
                        state_d = we_q ? S_DONE : S_CAPTURE;
                        req_d   = 1'b0;
                        pwe_d   = 1'b0;
                    end else begin
                        beat_d   = beat_q + BW'(1);
                        paddr_d  = beat_addr(addr_q, beat_q + BW'(1));
                        pbe_d    = beat_be(size_q, beat_q + BW'(1));
                        pwdata_d = beat_wdata(data_q, beat_q + BW'(1));
                    end
                end
            end
            S_CAPTURE: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase

        // Read data lands the cycle after its grant, independent of whether
        // the following beat is granted. Lanes past the access size are dropped.
        if (pend_q) begin
            for (int j = 0; j < L; j++) begin
                if (pend_be_q[j] && (int'(pend_beat_q) * L + j) < NB)
                    rbuf_d[8 * (int'(pend_beat_q) * L + j) +: 8] = mem_rdata_i[8 * j +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            req_q       <= 1'b0;
            pwe_q       <= 1'b0;
            paddr_q     <= '0;
            pbe_q       <= '0;
            pwdata_q    <= '0;
            rbuf_q      <= '0;
            pend_q      <= 1'b0;
            pend_beat_q <= '0;
            pend_be_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            req_q       <= req_d;
            pwe_q       <= pwe_d;
            paddr_q     <= paddr_d;
            pbe_q       <= pbe_d;
            pwdata_q    <= pwdata_d;
            rbuf_q      <= rbuf_d;
            pend_q      <= pend_d;
            pend_beat_q <= pend_beat_d;
            pend_be_q   <= pend_be_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = paddr_q;
    assign mem_we_o    = pwe_q;
    assign mem_be_o    = pbe_q;
    assign mem_wdata_o = pwdata_q;

    assign stall_o = ((state_q == S_IDLE) && op_valid_i) || (state_q == S_ACCESS) ||
                     (state_q == S_CAPTURE);

    // IDLE is a combinational bypass; DONE presents the result for one cycle;
    // every other state sends a bubble to WB.
    always_comb begin
        wd_o   = wd_q;
        wreg_o = 1'b0;
        data_o = '0;
        case (state_q)
            S_IDLE: begin
                wd_o   = wd_i;
                wreg_o = wreg_i & ~op_valid_i;
                data_o = data_i;
            end
            S_DONE: begin
                wreg_o = wreg_q & ~we_q;
                data_o = we_q ? '0 : extend(rbuf_q, size_q, uns_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu_serial.sv
module tb_mem_lsu_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        op_valid[2], op_we[2], op_uns[2], wreg_i[2], gnt[2];
    logic [1:0]  op_size[2];
    logic [31:0] addr_i[2], data_i[2];
    logic [4:0]  wd_i[2];
    logic [7:0]  rdata0;
    logic [31:0] rdata1;
    logic        req[2], mwe[2], stall[2], wreg_o[2];
    logic [31:0] maddr[2], data_o[2];
    logic [4:0]  wd_o[2];
    logic        be0;
    logic [3:0]  be1;
    logic [7:0]  mwd0;
    logic [31:0] mwd1;
    logic [3:0]  be[2];
    logic [31:0] wdat[2];

    assign be[0]   = {3'b000, be0};
    assign be[1]   = be1;
    assign wdat[0] = {24'h0, mwd0};
    assign wdat[1] = mwd1;

    mem_lsu_serial #(.XLEN(32), .MEM_W(8), .ADDR_W(32), .REG_AW(5)) u8 (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid[0]), .op_we_i(op_we[0]), .op_size_i(op_size[0]),
        .op_unsigned_i(op_uns[0]), .addr_i(addr_i[0]), .data_i(data_i[0]),
        .wd_i(wd_i[0]), .wreg_i(wreg_i[0]), .mem_gnt_i(gnt[0]), .mem_rdata_i(rdata0),
        .mem_req_o(req[0]), .mem_addr_o(maddr[0]), .mem_we_o(mwe[0]), .mem_be_o(be0),
        .mem_wdata_o(mwd0), .stall_o(stall[0]), .wd_o(wd_o[0]), .wreg_o(wreg_o[0]),
        .data_o(data_o[0]));

    mem_lsu_serial #(.XLEN(32), .MEM_W(32), .ADDR_W(32), .REG_AW(5)) u32 (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid[1]), .op_we_i(op_we[1]), .op_size_i(op_size[1]),
        .op_unsigned_i(op_uns[1]), .addr_i(addr_i[1]), .data_i(data_i[1]),
        .wd_i(wd_i[1]), .wreg_i(wreg_i[1]), .mem_gnt_i(gnt[1]), .mem_rdata_i(rdata1),
        .mem_req_o(req[1]), .mem_addr_o(maddr[1]), .mem_we_o(mwe[1]), .mem_be_o(be1),
        .mem_wdata_o(mwd1), .stall_o(stall[1]), .wd_o(wd_o[1]), .wreg_o(wreg_o[1]),
        .data_o(data_o[1]));

    logic [7:0]  mem[4096];       // memory behind the port, written from DUT beats
    logic [7:0]  ref_mem[4096];   // what memory should hold, by whole-access rules
    logic        rdp[2];
    logic [31:0] rdv[2];
    int          n_chk = 0, n_err = 0;
    logic [31:0] last_data;
    int          last_stall;
    logic [3:0]  first_be;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd3) ? 4 : (1 << sz);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        int b;
        logic [31:0] v;
        b = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < b; i++) v = v | (32'(ref_mem[(int'(a) + i) & 4095]) << (8 * i));
        if (!uns && b < 4 && v[8 * b - 1]) v = v | (32'hFFFF_FFFF << (8 * b));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(int'(a) + i) & 4095] = 8'(d >> (8 * i));
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        mem[a & 4095] = v;
        ref_mem[a & 4095] = v;
    endtask

    // Memory responder, called once per negedge after the grant is chosen.
    task automatic resp(input int s);
        int lw;
        int a;
        lw = (s == 0) ? 1 : 4;
        if (s == 0) rdata0 = rdp[0] ? rdv[0][7:0] : 8'($urandom);
        else        rdata1 = rdp[1] ? rdv[1] : $urandom;
        rdp[s] = 1'b0;
        if (req[s] && gnt[s]) begin
            a = int'(maddr[s][11:0]);
            if (mwe[s]) begin
                for (int j = 0; j < lw; j++)
                    if (be[s][j]) mem[(a + j) & 4095] = wdat[s][8 * j +: 8];
            end else begin
                rdp[s] = 1'b1;
                rdv[s] = 32'h0;
                for (int j = 0; j < lw; j++) rdv[s][8 * j +: 8] = mem[(a + j) & 4095];
            end
        end
    endtask

    task automatic run_op(input int s, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] w,
                          input logic wr, input int hold_beat, input int hold_len,
                          input bit rnd, input string tag);
        int lw, nb, nbeat, granted, nog, hl, stl, perr, rem, diffs;
        bit done;
        logic [31:0] exp_v, dres;
        logic [3:0] be_e;
        logic wres;
        logic [4:0] wdres;
        lw = (s == 0) ? 1 : 4;
        nb = nbytes(sz);
        nbeat = (nb + lw - 1) / lw;
        exp_v = we ? 32'h0 : model_load(a, sz, uns);
        granted = 0; nog = 0; hl = hold_len; stl = 0; perr = 0; done = 0;
        dres = 32'h0; wres = 1'b0; wdres = 5'h0; first_be = 4'h0;
        @(negedge clk);
        op_valid[s] = 1'b1; op_we[s] = we; op_size[s] = sz; op_uns[s] = uns;
        addr_i[s] = a; data_i[s] = d; wd_i[s] = w; wreg_i[s] = wr;
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) @(negedge clk);
            if (req[s]) begin
                if (granted >= nbeat) perr++;
                else begin
                    rem = nb - granted * lw;
                    be_e = 4'h0;
                    for (int j = 0; j < lw; j++) if (j < rem) be_e[j] = 1'b1;
                    if (maddr[s] !== a + 32'(granted * lw)) perr++;
                    if (be[s] !== be_e) perr++;
                    if (mwe[s] !== we) perr++;
                    if (we)
                        for (int j = 0; j < lw; j++)
                            if (be_e[j] && wdat[s][8 * j +: 8] !== 8'(d >> (8 * (granted * lw + j))))
                                perr++;
                end
            end
            if (req[s] && granted == hold_beat && hl > 0) begin
                gnt[s] = 1'b0;
                hl--;
            end else begin
                gnt[s] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (req[s]) begin
                if (gnt[s]) begin
                    if (granted == 0) first_be = be[s];
                    granted++;
                end else nog++;
            end
            resp(s);
            #1;
            if (stall[s]) begin
                stl++;
                if (wreg_o[s] !== 1'b0) perr++;
            end else begin
                done = 1;
                dres = data_o[s]; wres = wreg_o[s]; wdres = wd_o[s];
            end
        end
        op_valid[s] = 1'b0;
        gnt[s] = 1'b0;
        last_data = dres;
        last_stall = stl;
        if (!done) begin
            n_chk++; n_err++;
            $display("FAIL %s timeout: stall never dropped within 400 cycles", tag);
            return;
        end
        chk({tag, " data"}, 64'(dres), 64'(exp_v));
        chk({tag, " wreg"}, 64'(wres), 64'(we ? 1'b0 : wr));
        chk({tag, " wd"}, 64'(wdres), 64'(w));
        chk({tag, " stall"}, 64'(stl), 64'(nbeat + (we ? 1 : 2) + nog));
        chk({tag, " port"}, 64'(perr), 64'(0));
        chk({tag, " beats"}, 64'(granted), 64'(nbeat));
        if (we) model_store(a, sz, d);
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk({tag, " mem"}, 64'(diffs), 64'(0));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] d;
        bit          pre;
        logic [31:0] pv;
        logic [31:0] exp_d;
        logic        exp_wreg;
        int          exp_stall;
    } vec_t;

    vec_t tv[12];

    initial begin
        int hit, granted, bad;
        tv[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, 32'h44332211, 32'h44332211, 1'b1, 6};
        tv[1]  = '{1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 1, 32'h00000080, 32'hFFFFFF80, 1'b1, 3};
        tv[2]  = '{1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 0, 32'h0,        32'h00000080, 1'b1, 3};
        tv[3]  = '{1'b1, 2'd1, 1'b0, 32'h010, 32'hABCD1234, 0, 32'h0, 32'h0,        1'b0, 3};
        tv[4]  = '{1'b0, 2'd1, 1'b0, 32'h010, 32'h0, 0, 32'h0,        32'h00001234, 1'b1, 4};
        tv[5]  = '{1'b0, 2'd0, 1'b0, 32'h011, 32'h0, 0, 32'h0,        32'h00000012, 1'b1, 3};
        tv[6]  = '{1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 1, 32'h00009ABC, 32'hFFFF9ABC, 1'b1, 4};
        tv[7]  = '{1'b0, 2'd1, 1'b1, 32'h301, 32'h0, 0, 32'h0,        32'h00009ABC, 1'b1, 4};
        tv[8]  = '{1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, 0, 32'h0, 32'h0,        1'b0, 5};
        tv[9]  = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, 32'h0,        32'hDEADBEEF, 1'b1, 6};
        tv[10] = '{1'b0, 2'd3, 1'b0, 32'h402, 32'h0, 0, 32'h0,        32'h0000DEAD, 1'b1, 6};
        tv[11] = '{1'b0, 2'd1, 1'b0, 32'h402, 32'h0, 0, 32'h0,        32'hFFFFDEAD, 1'b1, 4};

        for (int i = 0; i < 4096; i++) begin
            mem[i] = (i >= 32'h800) ? 8'($urandom) : 8'h00;
            ref_mem[i] = mem[i];
        end
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            op_valid[s] = 0; op_we[s] = 0; op_size[s] = 0; op_uns[s] = 0; addr_i[s] = 0;
            data_i[s] = 0; wd_i[s] = 0; wreg_i[s] = 0; gnt[s] = 0; rdp[s] = 0; rdv[s] = 0;
        end
        rdata0 = 8'h0; rdata1 = 32'h0;

        // Reset state and pass-through while held in reset
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("rst req", 64'(req[s]), 64'(0));
            chk("rst we", 64'(mwe[s]), 64'(0));
            chk("rst addr", 64'(maddr[s]), 64'(0));
            chk("rst be", 64'(be[s]), 64'(0));
            chk("rst wdata", 64'(wdat[s]), 64'(0));
        end
        data_i[0] = 32'h5A5A_0001; wreg_i[0] = 1'b1; wd_i[0] = 5'd9;
        #1;
        chk("pass data", 64'(data_o[0]), 64'(32'h5A5A_0001));
        chk("pass wreg", 64'(wreg_o[0]), 64'(1));
        chk("pass wd", 64'(wd_o[0]), 64'(9));
        chk("pass stall", 64'(stall[0]), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors on the byte-wide port
        for (int i = 0; i < 12; i++) begin
            if (tv[i].pre)
                for (int b = 0; b < 4; b++) poke(int'(tv[i].a) + b, 8'(tv[i].pv >> (8 * b)));
            run_op(0, tv[i].we, tv[i].sz, tv[i].uns, tv[i].a, tv[i].d, 5'(i + 1), 1'b1,
                   -1, 0, 0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tdata", i), 64'(last_data), 64'(tv[i].exp_d));
            chk($sformatf("vec%0d tstall", i), 64'(last_stall), 64'(tv[i].exp_stall));
        end
        chk("sh byte0", 64'(mem[16]), 64'(8'h34));
        chk("sh byte1", 64'(mem[17]), 64'(8'h12));
        chk("sh byte2", 64'(mem[18]), 64'(8'h00));

        // Grant withheld for 3 cycles on beat 1 of a word load
        run_op(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd3, 1'b1, 1, 3, 0, "hold");
        chk("hold data", 64'(last_data), 64'(32'h44332211));
        chk("hold stall", 64'(last_stall), 64'(9));

        // 32-bit port: one-beat half load with junk in the upper lanes, one-beat word store
        poke(6, 8'h0D); poke(7, 8'hF0); poke(8, 8'hAA); poke(9, 8'hBB);
        run_op(1, 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 5'd7, 1'b1, -1, 0, 0, "w32 lh");
        chk("w32 lh data", 64'(last_data), 64'(32'hFFFFF00D));
        chk("w32 lh be", 64'(first_be), 64'(4'b0011));
        run_op(1, 1'b1, 2'd2, 1'b0, 32'h6, 32'h11223344, 5'd7, 1'b1, -1, 0, 0, "w32 sw");
        chk("w32 sw be", 64'(first_be), 64'(4'b1111));
        chk("w32 sw stall", 64'(last_stall), 64'(2));
        chk("w32 sw mem", 64'({mem[9], mem[8], mem[7], mem[6]}), 64'(32'h11223344));

        // Reset in the middle of a word store, during beat 2
        @(negedge clk);
        op_valid[0] = 1'b1; op_we[0] = 1'b1; op_size[0] = 2'd2; op_uns[0] = 1'b0;
        addr_i[0] = 32'h20; data_i[0] = 32'hCAFEF00D; wd_i[0] = 5'd1; wreg_i[0] = 1'b1;
        hit = 0; granted = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (req[0] && granted == 2) begin
                hit = 1;
                break;
            end
            gnt[0] = 1'b1;
            if (req[0]) granted++;
            resp(0);
        end
        chk("rstmid reached", 64'(hit), 64'(1));
        chk("rstmid addr", 64'(maddr[0]), 64'(32'h22));
        gnt[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstmid req", 64'(req[0]), 64'(0));
        chk("rstmid we", 64'(mwe[0]), 64'(0));
        op_valid[0] = 1'b0;
        rdp[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        data_i[0] = 32'h5; wreg_i[0] = 1'b1; wd_i[0] = 5'd4; gnt[0] = 1'b1;
        #1;
        chk("rstrel data", 64'(data_o[0]), 64'(32'h5));
        chk("rstrel stall", 64'(stall[0]), 64'(0));
        chk("rstrel wreg", 64'(wreg_o[0]), 64'(1));
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (req[0] !== 1'b0 || mwe[0] !== 1'b0) bad++;
            resp(0);
        end
        gnt[0] = 1'b0;
        chk("rstrel idle", 64'(bad), 64'(0));
        chk("rstmid partial", 64'({mem[35], mem[34], mem[33], mem[32]}), 64'(32'h0000F00D));
        ref_mem[32] = 8'h0D; ref_mem[33] = 8'hF0;
        run_op(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd2, 1'b1, -1, 0, 0, "post rst");

        // Randomised traffic on both ports with random grant gaps
        for (int i = 0; i < 80; i++) begin
            run_op(i % 2, 1'($urandom), 2'($urandom), 1'($urandom),
                   32'($urandom_range(32'h800, 32'hF00)), $urandom, 5'($urandom), 1'($urandom),
                   -1, 0, 1, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
